// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg
// Shared definitions for the frequency-meter control blocks:
//   state_e    - gate-window sequencer states
//   gate_len   - gate length for a given range, clamped to at least one cycle
//   cnt_width  - bit width needed to hold a count value (never below 1)
package freq_meter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_GATE,
    ST_LATCH,
    ST_HOLD
  } state_e;

  // Range k gate = gate_cycles / range_div^k, floored by repeated integer
  // division, then clamped to 1 so the fastest ranges still open a window.
  function automatic int unsigned gate_len(input int unsigned rng,
                                           input int unsigned gate_cycles,
                                           input int unsigned range_div);
    int unsigned g;
    g = gate_cycles;
    for (int unsigned i = 0; i < rng; i++) begin
      if (range_div != 0) g = g / range_div;
    end
    if (g < 1) g = 1;
    return g;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val == 0) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl
// Gate-window sequencer for the frequency meter: CLEAR -> GATE -> LATCH ->
// (HOLD) -> IDLE or rerun. Any change of testMode/modeControl aborts the
// current window and restarts from CLEAR.
//
// Ports:
//   clkControl  in   reference clock, rising edge
//   reset       in   synchronous active-high reset
//   testMode    in   range select (MODE_W bits)
//   modeControl in   measurement mode; only changes matter here
//   enable      out  counter enable, high for the gate window
//   clear       out  one-cycle counter clear
//   latch       out  one-cycle display latch strobe
//   measDone    out  one-cycle pulse coincident with latch
//   busy        out  high while in CLEAR, GATE or LATCH
//
// Build option: define FREQ_GATE_AUTO_RERUN_EN to restart measurements
// continuously after HOLD; otherwise the block parks in IDLE after one
// measurement until the next reset or input change.
module freq_gate_ctrl
  import freq_meter_pkg::*;
#(
  parameter int unsigned MODE_W      = 2,
  parameter int unsigned GATE_CYCLES = 1000000,
  parameter int unsigned RANGE_DIV   = 10,
  parameter int unsigned HOLD_CYCLES = 0
) (
  input  logic              clkControl,
  input  logic              reset,
  input  logic [MODE_W-1:0] testMode,
  input  logic              modeControl,
  output logic              enable,
  output logic              clear,
  output logic              latch,
  output logic              measDone,
  output logic              busy
);

  localparam int unsigned NUM_RANGES = 1 << MODE_W;
  // One counter times both the gate and the hold phase, so size it for the
  // larger of the two.
  localparam int unsigned CNT_MAX = (GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef FREQ_GATE_AUTO_RERUN_EN
  localparam state_e POST_HOLD = ST_CLEAR;
`else
  localparam state_e POST_HOLD = ST_IDLE;
`endif

  // Constant per-range gate lengths.
  logic [CNT_W-1:0] gate_tbl [NUM_RANGES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RANGES; gi++) begin : g_gate_tbl
      assign gate_tbl[gi] = CNT_W'(gate_len(gi, GATE_CYCLES, RANGE_DIV));
    end
  endgenerate

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MODE_W-1:0] range_q;
  logic              mode_ctl_q;
  logic              changed;
  logic              enable_q, clear_q, latch_q, meas_done_q, busy_q;

  assign changed = (testMode != range_q) || (modeControl != mode_ctl_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: ;
      ST_CLEAR: begin
        state_d = ST_GATE;
        cnt_d   = gate_tbl[range_q];
      end
      ST_GATE: begin
        // Counter holds the remaining gate cycles including the current one.
        if (cnt_q <= CNT_ONE) state_d = ST_LATCH;
        else                  cnt_d   = cnt_q - CNT_ONE;
      end
      ST_LATCH: begin
        if (HOLD_CYCLES > 0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_CNT;
        end else begin
          state_d = POST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q <= CNT_ONE) state_d = POST_HOLD;
        else                  cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A switch change restarts from every state, including CLEAR itself.
    if (changed) state_d = ST_CLEAR;
  end

  always_ff @(posedge clkControl) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      range_q     <= testMode;
      mode_ctl_q  <= modeControl;
      cnt_q       <= '0;
      enable_q    <= 1'b0;
      clear_q     <= 1'b0;
      latch_q     <= 1'b0;
      meas_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (changed) begin
        range_q    <= testMode;
        mode_ctl_q <= modeControl;
      end
      // Outputs are the registered decode of the current state. Enable is
      // also cut on the aborting edge so an interrupted window stops at once.
      enable_q    <= (state_q == ST_GATE) && !changed;
      clear_q     <= (state_q == ST_CLEAR);
      latch_q     <= (state_q == ST_LATCH);
      meas_done_q <= (state_q == ST_LATCH);
      busy_q      <= (state_q == ST_CLEAR) || (state_q == ST_GATE) || (state_q == ST_LATCH);
    end
  end

  assign enable   = enable_q;
  assign clear    = clear_q;
  assign latch    = latch_q;
  assign measDone = meas_done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb_freq_gate_ctrl
// Bench for freq_gate_ctrl with MODE_W=2, GATE_CYCLES=100, RANGE_DIV=10,
// HOLD_CYCLES=5. The reference model computes, from the cycle distance since
// the last restart, which phase of the measurement the block is in.
module tb_freq_gate_ctrl;

  localparam int MODE_W = 2;
  localparam int GC     = 100;
  localparam int RD     = 10;
  localparam int HC     = 5;

`ifdef FREQ_GATE_AUTO_RERUN_EN
  localparam bit RERUN = 1'b1;
`else
  localparam bit RERUN = 1'b0;
`endif

  // Phase names used by the model only.
  localparam int PH_IDLE = 0, PH_CLEAR = 1, PH_GATE = 2, PH_LATCH = 3, PH_HOLD = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [MODE_W-1:0] tm  = '0;
  logic              mc  = 1'b0;
  logic              enable, clear, latch, measDone, busy;

  always #5 clk = ~clk;

  freq_gate_ctrl #(
    .MODE_W(MODE_W), .GATE_CYCLES(GC), .RANGE_DIV(RD), .HOLD_CYCLES(HC)
  ) dut (
    .clkControl (clk),
    .reset      (rst),
    .testMode   (tm),
    .modeControl(mc),
    .enable     (enable),
    .clear      (clear),
    .latch      (latch),
    .measDone   (measDone),
    .busy       (busy)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Model state
  int              ecount    = 0;
  int              anchor    = 0;
  int              cur_g     = GC;
  int              cur_phase = PH_IDLE;
  logic [MODE_W-1:0] tm_seen = '0;
  logic            mc_seen   = 1'b0;
  logic [4:0]      exp_vec   = '0;   // {enable, clear, latch, measDone, busy}

  function automatic int ref_gate(input int r);
    int g = GC;
    for (int i = 0; i < r; i++) g = g / RD;
    if (g < 1) g = 1;
    return g;
  endfunction

  // Phase occupied d cycles after the sequence restarted with gate length g.
  function automatic int phase_of(input int d, input int g);
    int p = g + 2 + HC;
    if (RERUN && d >= p) d = d % p;
    if (d == 0)           return PH_CLEAR;
    if (d <= g)           return PH_GATE;
    if (d == g + 1)       return PH_LATCH;
    if (d <= g + 1 + HC)  return PH_HOLD;
    return PH_IDLE;
  endfunction

  function automatic logic [4:0] decode(input int ph);
    case (ph)
      PH_CLEAR: return 5'b01001;
      PH_GATE:  return 5'b10001;
      PH_LATCH: return 5'b00111;
      default:  return 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] obs();
    return {enable, clear, latch, measDone, busy};
  endfunction

  // Apply one cycle of inputs and advance the model to what the outputs
  // should show just after that edge.
  task automatic step(input bit r, input logic [MODE_W-1:0] m, input logic c);
    bit chg;
    @(negedge clk);
    rst = r; tm = m; mc = c;
    @(posedge clk);
    #1;
    chg = (m !== tm_seen) || (c !== mc_seen);
    if (r) begin
      exp_vec = '0;
      anchor  = ecount; tm_seen = m; mc_seen = c; cur_g = ref_gate(int'(m));
    end else begin
      exp_vec = decode(cur_phase);
      if (chg) begin
        exp_vec[4] = 1'b0;
        anchor  = ecount; tm_seen = m; mc_seen = c; cur_g = ref_gate(int'(m));
      end
    end
    cur_phase = phase_of(ecount - anchor, cur_g);
    ecount++;
  endtask

  task automatic test_reset();
    int en_n = 0, busy_n = 0, lat_n = 0;
    step(1, 0, 0);
    step(1, 0, 0);
    vectors++;
    if (obs() !== 5'b00000) begin
      miscompares++; $display("FAIL reset_outputs: got %b want 00000", obs());
    end
    for (int i = 0; i < 110; i++) begin
      step(0, 0, 0);
      vectors++;
      if (obs() !== exp_vec) begin
        miscompares++; $display("FAIL reset_seq cyc %0d: got %b want %b", i, obs(), exp_vec);
      end
      en_n += int'(enable); busy_n += int'(busy); lat_n += int'(latch);
    end
    vectors += 3;
    if (en_n !== 100)  begin miscompares++; $display("FAIL reset_enable_width: got %0d want 100", en_n); end
    if (busy_n !== 102) begin miscompares++; $display("FAIL reset_busy_width: got %0d want 102", busy_n); end
    if (lat_n !== 1)   begin miscompares++; $display("FAIL reset_latch_count: got %0d want 1", lat_n); end
    $display("test_reset: enable=%0d busy=%0d latch=%0d", en_n, busy_n, lat_n);
  endtask

  task automatic test_ranges();
    int want [3] = '{10, 1, 1};
    for (int r = 1; r <= 3; r++) begin
      int en_n = 0;
      bit got_latch = 0;
      step(0, MODE_W'(r), mc);
      for (int i = 0; i < 40 && !got_latch; i++) begin
        step(0, tm, mc);
        vectors++;
        if (obs() !== exp_vec) begin
          miscompares++; $display("FAIL range%0d_seq cyc %0d: got %b want %b", r, i, obs(), exp_vec);
        end
        en_n += int'(enable);
        got_latch = latch;
      end
      for (int i = 0; i < 10; i++) step(0, tm, mc);  // let it settle (IDLE or HOLD)
      vectors++;
      if (!got_latch || en_n !== want[r-1]) begin
        miscompares++;
        $display("FAIL range%0d_enable_width: got %0d latch=%0b want %0d", r, en_n, got_latch, want[r-1]);
      end
      $display("test_ranges: range %0d enable width %0d", r, en_n);
    end
  endtask

  task automatic test_abort();
    int en_n = 0, lat_n = 0, clr_n = 0;
    step(0, 0, ~mc);
    for (int i = 0; i < 60 && en_n < 50; i++) begin
      step(0, 0, mc);
      en_n += int'(enable);
    end
    vectors++;
    if (en_n !== 50) begin miscompares++; $display("FAIL abort_reach50: got %0d want 50", en_n); end
    step(0, 1, mc);  // switch to range 1 mid-window
    vectors++;
    if (enable !== 1'b0 || latch !== 1'b0) begin
      miscompares++; $display("FAIL abort_enable_drop: got en=%b lat=%b want 0 0", enable, latch);
    end
    en_n = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, mc);
      vectors++;
      if (obs() !== exp_vec) begin
        miscompares++; $display("FAIL abort_seq cyc %0d: got %b want %b", i, obs(), exp_vec);
      end
      if (i == 0) clr_n = int'(clear);
      en_n += int'(enable); lat_n += int'(latch);
    end
    vectors += 3;
    if (clr_n !== 1) begin miscompares++; $display("FAIL abort_clear: got %0d want 1", clr_n); end
    if (en_n !== 10) begin miscompares++; $display("FAIL abort_new_gate: got %0d want 10", en_n); end
    if (lat_n !== 1) begin miscompares++; $display("FAIL abort_latch_count: got %0d want 1", lat_n); end
    $display("test_abort: new gate %0d latches %0d", en_n, lat_n);
  endtask

  task automatic test_coincident_change();
    int lat_n = 0;
    step(0, 1, ~mc);                        // restart, range 1 (G=10)
    for (int i = 0; i < 10; i++) step(0, 1, mc);
    step(0, 1, ~mc);                        // edge that would enter LATCH
    vectors++;
    if (latch !== 1'b0) begin miscompares++; $display("FAIL coinc_edge_latch: got %b want 0", latch); end
    for (int i = 0; i < 14; i++) begin
      step(0, 1, mc);
      vectors++;
      if (obs() !== exp_vec) begin
        miscompares++; $display("FAIL coinc_seq cyc %0d: got %b want %b", i, obs(), exp_vec);
      end
      if (i == 0) begin
        vectors++;
        if (clear !== 1'b1) begin miscompares++; $display("FAIL coinc_clear: got %b want 1", clear); end
      end
      if (i < 11) lat_n += int'(latch);
    end
    vectors++;
    if (lat_n !== 0) begin miscompares++; $display("FAIL coinc_no_latch: got %0d want 0", lat_n); end
    $display("test_coincident_change: latches before restart window end %0d", lat_n);
  endtask

  task automatic test_run();
    int pos [$];
    step(0, 0, ~mc);
    for (int i = 1; i <= 230; i++) begin
      step(0, 0, mc);
      vectors++;
      if (obs() !== exp_vec) begin
        miscompares++; $display("FAIL run_seq cyc %0d: got %b want %b", i, obs(), exp_vec);
      end
      if (latch) pos.push_back(i);
    end
    vectors++;
    if (RERUN) begin
      if (pos.size() !== 2 || (pos[1] - pos[0]) !== 107) begin
        miscompares++;
        $display("FAIL run_period: got %0d latches spacing %0d want 2 spacing 107",
                 pos.size(), (pos.size() > 1) ? pos[1] - pos[0] : 0);
      end
    end else begin
      if (pos.size() !== 1 || obs() !== 5'b00000) begin
        miscompares++; $display("FAIL run_single: got %0d latches end=%b want 1 00000", pos.size(), obs());
      end
    end
    $display("test_run: %0d latch pulses, first at cycle %0d", pos.size(),
             (pos.size() > 0) ? pos[0] : -1);
  endtask

  task automatic test_reset_mid_gate();
    int en_n = 0;
    step(0, 0, ~mc);
    for (int i = 0; i < 30; i++) step(0, 0, mc);
    step(1, 0, mc);
    vectors++;
    if (obs() !== 5'b00000) begin miscompares++; $display("FAIL midreset_outputs: got %b want 00000", obs()); end
    for (int i = 0; i < 105; i++) begin
      step(0, 0, mc);
      vectors++;
      if (obs() !== exp_vec) begin
        miscompares++; $display("FAIL midreset_seq cyc %0d: got %b want %b", i, obs(), exp_vec);
      end
      en_n += int'(enable);
    end
    vectors++;
    if (en_n !== 100) begin miscompares++; $display("FAIL midreset_fresh_gate: got %0d want 100", en_n); end
    $display("test_reset_mid_gate: fresh gate %0d", en_n);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 500; i++) begin
      bit r = ($urandom_range(0, 199) == 0);
      logic [MODE_W-1:0] m = tm;
      logic c = mc;
      if ($urandom_range(0, 29) == 0) m = MODE_W'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) c = ~c;
      step(r, m, c);
      vectors++;
      if (obs() !== exp_vec) begin
        miscompares++; bad++;
        $display("FAIL random_seq cyc %0d: got %b want %b", i, obs(), exp_vec);
      end
    end
    $display("test_random: 500 cycles, %0d differences", bad);
  endtask

  initial begin
    test_reset();
    test_ranges();
    test_abort();
    test_coincident_change();
    test_run();
    test_reset_mid_gate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
